// File: rtl/modmult_sq_pkg.sv
// Shared types for the shift-add modular multiplier/squarer and its bench.
package modmult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic {MM_MUL = 1'b0, MM_SQR = 1'b1} mode_t;

    // Index of the highest set bit plus one; 0 for a zero value.
    function automatic int bit_len(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) n = i + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/modmult_sq_if.sv
// Request/response bundle between the exponentiation controller and modmult_sq.
interface modmult_sq_if import modmult_pkg::*; #(parameter int MPWID = 32);

    logic             ds;
    mode_t            mode;
    logic             abort;
    logic [MPWID-1:0] mpand;
    logic [MPWID-1:0] mplier;
    logic [MPWID-1:0] modulus;
    logic [MPWID-1:0] product;
    logic             ready;
    logic             busy;
    logic             err;

    modport master (
        output ds, mode, abort, mpand, mplier, modulus,
        input  product, ready, busy, err
    );

    modport slave (
        input  ds, mode, abort, mpand, mplier, modulus,
        output product, ready, busy, err
    );

endinterface

// File: rtl/modmult_sq_modadd.sv
// Combinational (x + y) mod m for x, y < m: one wide add, one conditional subtract.
module modadd #(
    parameter int MPWID = 32
) (
    input  logic [MPWID-1:0] x,
    input  logic [MPWID-1:0] y,
    input  logic [MPWID-1:0] m,
    output logic [MPWID-1:0] sum
);

    // The carry bit takes part in the compare, so 2*(m-1) never wraps.
    function automatic logic [MPWID-1:0] reduce(input logic [MPWID:0] raw,
                                                input logic [MPWID-1:0] md);
        logic [MPWID:0] mw;
        mw = {1'b0, md};
        if (raw >= mw) return MPWID'(raw - mw);
        return raw[MPWID-1:0];
    endfunction

    logic [MPWID:0] raw;

    assign raw = {1'b0, x} + {1'b0, y};
    assign sum = reduce(raw, m);

endmodule

// File: rtl/modmult_sq.sv
// LSB-first interleaved add/double modular multiplier with square mode,
// operand swap (latency tracks the smaller operand), range check and abort.
module modmult_sq import modmult_pkg::*; #(
    parameter int MPWID = 32
) (
    input  logic         clk,
    input  logic         reset,
    modmult_sq_if.slave  bus
);

    state_t           state;
    logic [MPWID-1:0] a;
    logic [MPWID-1:0] mp;
    logic [MPWID-1:0] acc;
    logic [MPWID-1:0] m;
    logic             err_pend;

    logic [MPWID-1:0] op_b;
    logic             range_bad;
    logic             a_gt;
    logic [MPWID-1:0] acc_next;
    logic [MPWID-1:0] a_dbl;
    logic             accept;

    assign op_b      = (bus.mode == MM_SQR) ? bus.mpand : bus.mplier;
    assign range_bad = (bus.modulus == '0) || (bus.mpand >= bus.modulus) ||
                       (op_b >= bus.modulus);
    assign a_gt      = (bus.mpand >= op_b);
    assign accept    = (state == IDLE) && bus.ds;

    modadd #(.MPWID(MPWID)) u_acc (.x(acc), .y(a), .m(m), .sum(acc_next));
    modadd #(.MPWID(MPWID)) u_dbl (.x(a),   .y(a), .m(m), .sum(a_dbl));

    // Control: state and all visible outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            bus.product <= '0;
            bus.ready   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ds) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (mp == '0) begin
                        state       <= DONE;
                        bus.busy    <= 1'b0;
                        bus.ready   <= 1'b1;
                        bus.product <= acc;
                        bus.err     <= err_pend;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: an out-of-range request loads mp = 0 so it finishes on the
    // first RUN check with acc = 0.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc      <= '0;
            m        <= bus.modulus;
            err_pend <= range_bad;
            if (range_bad) begin
                a  <= '0;
                mp <= '0;
            end else if (a_gt) begin
                a  <= bus.mpand;
                mp <= op_b;
            end else begin
                a  <= op_b;
                mp <= bus.mpand;
            end
        end else if (state == RUN && mp != '0) begin
            if (mp[0]) acc <= acc_next;
            a  <= a_dbl;
            mp <= mp >> 1;
        end
    end

endmodule

// File: tb/tb_modmult_sq.sv
// Directed vector bench for modmult_sq: result, error flag and cycle-exact handshake.
module tb_modmult_sq;
    import modmult_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    modmult_sq_if #(.MPWID(W)) bus ();

    modmult_sq #(.MPWID(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] mpand;
        logic [W-1:0] mplier;
        logic [W-1:0] modulus;
        logic         mode;
        logic [W-1:0] product;
        logic         err;
        int           lat;
    } vec_t;

    vec_t vecs[11];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] md, input logic md_sq, input logic ab);
        @(negedge clk);
        bus.mpand   = x;
        bus.mplier  = y;
        bus.modulus = md;
        bus.mode    = md_sq ? MM_SQR : MM_MUL;
        bus.abort   = ab;
        bus.ds      = 1'b1;
        @(negedge clk);
        bus.ds    = 1'b0;
        bus.abort = 1'b0;
    endtask

    // Launches one request and follows it to completion; after acceptance the
    // operand inputs are scrambled to show they are no longer looked at.
    task automatic run_op(input vec_t v, input string tag, input logic ab);
        int   cycles;
        logic seen;
        logic busy_ok;
        start(v.mpand, v.mplier, v.modulus, v.mode, ab);
        bus.mpand   = $urandom;
        bus.mplier  = $urandom;
        bus.modulus = $urandom;
        busy_ok = bus.busy;
        cycles  = 0;
        seen    = 1'b0;
        while (!seen && cycles < 100) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.ready) seen = 1'b1;
            else if (!bus.busy) busy_ok = 1'b0;
        end
        check($sformatf("%s latency", tag), cycles, v.lat);
        check($sformatf("%s busy_while_running", tag), busy_ok, 1);
        check($sformatf("%s busy_at_ready", tag), bus.busy, 0);
        check($sformatf("%s product", tag), bus.product, v.product);
        check($sformatf("%s err", tag), bus.err, v.err);
        @(negedge clk);
        check($sformatf("%s ready_one_cycle", tag), bus.ready, 0);
        check($sformatf("%s product_held", tag), bus.product, v.product);
    endtask

    initial begin
        int rdy_cnt;
        vec_t v;

        vecs[0]  = '{929, 31, 997, 1'b0, 883, 1'b0, 6};
        vecs[1]  = '{31, 929, 997, 1'b0, 883, 1'b0, 6};
        vecs[2]  = '{929, 5000, 997, 1'b1, 636, 1'b0, 11};
        vecs[3]  = '{997, 7, 997, 1'b0, 0, 1'b1, 1};
        vecs[4]  = '{5, 7, 0, 1'b0, 0, 1'b1, 1};
        vecs[5]  = '{5, 997, 997, 1'b0, 0, 1'b1, 1};
        vecs[6]  = '{2, 3, 7, 1'b0, 6, 1'b0, 3};
        vecs[7]  = '{6, 9, 7, 1'b1, 1, 1'b0, 4};
        vecs[8]  = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 1'b0, 1, 1'b0, 33};
        vecs[9]  = '{1, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 1'b0, 32'hFFFF_FFFA, 1'b0, 2};
        vecs[10] = '{500, 0, 997, 1'b0, 0, 1'b0, 1};

        bus.ds = 1'b0; bus.abort = 1'b0; bus.mode = MM_MUL;
        bus.mpand = '0; bus.mplier = '0; bus.modulus = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset product", bus.product, 0);
        check("reset ready", bus.ready, 0);
        check("reset busy", bus.busy, 0);
        check("reset err", bus.err, 0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Abort sampled at edge k+4 of a 500*929 request: no result, outputs kept.
        start(500, 929, 997, 1'b0, 1'b0);
        rdy_cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready) rdy_cnt++;
        end
        check("abort busy_before", bus.busy, 1);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort busy_after", bus.busy, 0);
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready) rdy_cnt++;
        end
        check("abort no_ready", rdy_cnt, 0);
        check("abort product_kept", bus.product, 0);
        check("abort err_kept", bus.err, 0);

        // abort together with ds in IDLE: the request is accepted normally.
        run_op(vecs[6], "ds_with_abort", 1'b1);

        // Reset mid-RUN clears everything and the lost request never completes.
        start(929, 31, 997, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("midrun_reset product", bus.product, 0);
        check("midrun_reset ready", bus.ready, 0);
        check("midrun_reset busy", bus.busy, 0);
        check("midrun_reset err", bus.err, 0);
        rdy_cnt = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready) rdy_cnt++;
        end
        check("midrun_reset no_ready", rdy_cnt, 0);

        // ds pulses while RUN must not queue a second request.
        start(929, 31, 997, 1'b0, 1'b0);
        rdy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 2 || c == 3) begin
                bus.mpand = 2; bus.mplier = 3; bus.modulus = 7; bus.ds = 1'b1;
            end else begin
                bus.ds = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (bus.ready) begin
                rdy_cnt++;
                check("ds_in_run ready_edge", c, 6);
                check("ds_in_run product", bus.product, 883);
            end
        end
        bus.ds = 1'b0;
        check("ds_in_run ready_count", rdy_cnt, 1);

        // Normal service resumes afterwards.
        v = vecs[0];
        run_op(v, "after_ignored_ds", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
